// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter in front of a single-ported RAM, with timeout abort and sticky error.
// Optional MEM_ARBITER_RR_EN: round-robin between simultaneous requests instead of fixed dcache priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int unsigned CW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0]  RS_ACCESS  = 2'd2;
  localparam logic [1:0]  RS_ERROR   = 2'd3;
  localparam logic [31:0] ABORT_WORD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DSERVE = 2'd1,
    ISERVE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic w_dreq;
  logic w_ireq;
  logic w_req;
  logic w_ram_done;
  logic w_tmo;
  logic w_finish;
  logic w_abort;
  logic w_pick_i;

  assign w_dreq     = dREN | dWEN;
  assign w_ireq     = iREN;
  assign w_req      = (r_state == DSERVE) ? w_dreq :
                      (r_state == ISERVE) ? w_ireq : 1'b0;
  assign w_ram_done = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR);
  assign w_tmo      = (r_cnt == CNT_LAST);
  // A real RAM completion on the last allowed cycle wins over the abort.
  assign w_finish   = w_req & (w_ram_done | w_tmo);
  assign w_abort    = w_req & ~w_ram_done & w_tmo;

`ifdef MEM_ARBITER_RR_EN
  logic r_last_d;

  assign w_pick_i = w_ireq & (~w_dreq | r_last_d);

  // Remember which side took the most recent grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_d <= 1'b0;
    end else if ((r_state == IDLE) && (w_next == DSERVE)) begin
      r_last_d <= 1'b1;
    end else if ((r_state == IDLE) && (w_next == ISERVE)) begin
      r_last_d <= 1'b0;
    end else begin
      r_last_d <= r_last_d;
    end
  end
`else
  assign w_pick_i = w_ireq & ~w_dreq;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: arbitrate in IDLE, leave a serve state on completion, abort or withdrawal.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dreq && !w_pick_i) begin
          w_next = DSERVE;
        end else if (w_pick_i) begin
          w_next = ISERVE;
        end else begin
          w_next = IDLE;
        end
      end
      DSERVE, ISERVE: begin
        if (!w_req || w_finish) begin
          w_next = IDLE;
        end else begin
          w_next = r_state;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs: route the granted client to the RAM and pulse its wait low on completion.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    iload    = ramload;
    dload    = ramload;
    case (r_state)
      DSERVE: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~w_finish;
        if (w_abort) begin
          dload = ABORT_WORD;
        end else begin
          dload = ramload;
        end
      end
      ISERVE: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~w_finish;
        if (w_abort) begin
          iload = ABORT_WORD;
        end else begin
          iload = ramload;
        end
      end
      default: begin
        iwait = 1'b1;
        dwait = 1'b1;
      end
    endcase
  end

  // Serve-cycle counter; held at zero in IDLE so each grant starts a fresh count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (w_tmo) begin
      r_cnt <= r_cnt;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Sticky error: RAM ERROR or timeout abort on a live request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_err <= 1'b0;
    end else if (w_req && ((ramstate == RS_ERROR) || w_abort)) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT=4); expectations follow MEM_ARBITER_RR_EN when defined.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int n_cmp;
  int n_bad;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FREE;
    cyc();
    cyc();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30; ramload = 32'h0; ramstate = ACCESS;
    #2;
    n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL reset_iwait got %0h want 1", iwait); end
    n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL reset_dwait got %0h want 1", dwait); end
    n_cmp++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin n_bad++; $display("FAIL reset_strobes got %0h%0h want 00", ramREN, ramWEN); end
    n_cmp++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_bad++; $display("FAIL reset_bus got %h/%h want 0/0", ramaddr, ramstore); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0h want 0", err); end
    do_reset();
  endtask

  task automatic test_priority();
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hCAFEF00D; iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY;
    #2;
    n_cmp++; if (ramWEN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin n_bad++; $display("FAIL prio_idle got wen=%0h dw=%0h iw=%0h want 0 1 1", ramWEN, dwait, iwait); end
    cyc(); #2;
    n_cmp++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_bad++; $display("FAIL prio_dserve_strobes got wen=%0h ren=%0h want 1 0", ramWEN, ramREN); end
    n_cmp++; if (ramaddr !== 32'h200 || ramstore !== 32'hCAFEF00D) begin n_bad++; $display("FAIL prio_dserve_bus got %h/%h want 00000200/cafef00d", ramaddr, ramstore); end
    n_cmp++; if (iwait !== 1'b1 || dwait !== 1'b1) begin n_bad++; $display("FAIL prio_dserve_waits got iw=%0h dw=%0h want 1 1", iwait, dwait); end
    cyc(); ramstate = ACCESS; #2;
    n_cmp++; if (dwait !== 1'b0 || iwait !== 1'b1) begin n_bad++; $display("FAIL prio_dcomplete got dw=%0h iw=%0h want 0 1", dwait, iwait); end
    cyc(); dWEN = 1'b0; ramstate = BUSY; #2;
    n_cmp++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin n_bad++; $display("FAIL prio_gap got ren=%0h wen=%0h iw=%0h dw=%0h want 0 0 1 1", ramREN, ramWEN, iwait, dwait); end
    cyc(); #2;
    n_cmp++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h44 || ramstore !== 32'h0) begin n_bad++; $display("FAIL prio_iserve got ren=%0h wen=%0h addr=%h st=%h want 1 0 00000044 0", ramREN, ramWEN, ramaddr, ramstore); end
    cyc(); ramstate = ACCESS; ramload = 32'hA5A50001; #2;
    n_cmp++; if (iwait !== 1'b0 || dwait !== 1'b1 || iload !== 32'hA5A50001) begin n_bad++; $display("FAIL prio_icomplete got iw=%0h dw=%0h load=%h want 0 1 a5a50001", iwait, dwait, iload); end
    cyc(); iREN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_iread();
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; #2;
    n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL iread_idle_ren got %0h want 0", ramREN); end
    cyc(); #2;
    n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin n_bad++; $display("FAIL iread_cycle1 got ren=%0h addr=%h iw=%0h want 1 00000040 1", ramREN, ramaddr, iwait); end
    cyc(); ramstate = ACCESS; ramload = 32'h12345678; #2;
    n_cmp++; if (iwait !== 1'b0 || iload !== 32'h12345678 || dwait !== 1'b1) begin n_bad++; $display("FAIL iread_cycle2 got iw=%0h load=%h dw=%0h want 0 12345678 1", iwait, iload, dwait); end
    cyc(); iREN = 1'b0; ramstate = FREE; #2;
    n_cmp++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin n_bad++; $display("FAIL iread_after got iw=%0h ren=%0h want 1 0", iwait, ramREN); end
  endtask

  task automatic test_dread();
    dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
    cyc(); #2;
    n_cmp++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100) begin n_bad++; $display("FAIL dread_serve got ren=%0h wen=%0h addr=%h want 1 0 00000100", ramREN, ramWEN, ramaddr); end
    cyc(); ramstate = ACCESS; ramload = 32'hDEAD0002; #2;
    n_cmp++; if (dwait !== 1'b0 || dload !== 32'hDEAD0002 || iwait !== 1'b1) begin n_bad++; $display("FAIL dread_complete got dw=%0h load=%h iw=%0h want 0 dead0002 1", dwait, dload, iwait); end
    cyc(); dREN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_rr();
    logic [31:0] exp_addr;
    logic        exp_iw;
    logic        exp_dw;
`ifdef MEM_ARBITER_RR_EN
    exp_addr = 32'h600; exp_iw = 1'b0; exp_dw = 1'b1;
`else
    exp_addr = 32'h500; exp_iw = 1'b1; exp_dw = 1'b0;
`endif
    dREN = 1'b1; daddr = 32'h500; iREN = 1'b1; iaddr = 32'h600; ramstate = BUSY;
    cyc(); #2;
    n_cmp++; if (ramaddr !== exp_addr || ramREN !== 1'b1) begin n_bad++; $display("FAIL rr_grant got addr=%h ren=%0h want %h 1", ramaddr, ramREN, exp_addr); end
    cyc(); ramstate = ACCESS; #2;
    n_cmp++; if (iwait !== exp_iw || dwait !== exp_dw) begin n_bad++; $display("FAIL rr_complete got iw=%0h dw=%0h want %0h %0h", iwait, dwait, exp_iw, exp_dw); end
    cyc(); dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_timeout();
    #2;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_err_before got %0h want 0", err); end
    dREN = 1'b1; daddr = 32'h700; ramstate = BUSY; ramload = 32'h55AA55AA;
    for (int k = 1; k <= 3; k++) begin
      cyc(); #2;
      n_cmp++; if (dwait !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL tmo_serve%0d got dw=%0h err=%0h want 1 0", k, dwait, err); end
    end
    cyc(); #2;
    n_cmp++; if (dwait !== 1'b0 || dload !== 32'hBAD1BAD1) begin n_bad++; $display("FAIL tmo_abort got dw=%0h load=%h want 0 bad1bad1", dwait, dload); end
    n_cmp++; if (iwait !== 1'b1 || iload !== 32'h55AA55AA) begin n_bad++; $display("FAIL tmo_other got iw=%0h iload=%h want 1 55aa55aa", iwait, iload); end
    cyc(); dREN = 1'b0; ramstate = FREE; #2;
    n_cmp++; if (err !== 1'b1 || dwait !== 1'b1) begin n_bad++; $display("FAIL tmo_err_set got err=%0h dw=%0h want 1 1", err, dwait); end
    cyc(); cyc(); #2;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err_sticky got %0h want 1", err); end
  endtask

  task automatic test_ram_error();
    do_reset(); #2;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rerr_cleared got %0h want 0", err); end
    iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
    cyc(); ramstate = ERROR; #2;
    n_cmp++; if (iwait !== 1'b0 || dwait !== 1'b1) begin n_bad++; $display("FAIL rerr_complete got iw=%0h dw=%0h want 0 1", iwait, dwait); end
    cyc(); iREN = 1'b0; ramstate = FREE; #2;
    n_cmp++; if (err !== 1'b1 || iwait !== 1'b1) begin n_bad++; $display("FAIL rerr_set got err=%0h iw=%0h want 1 1", err, iwait); end
  endtask

  task automatic test_withdraw();
    do_reset();
    dREN = 1'b1; daddr = 32'h900; ramstate = BUSY;
    cyc(); #2;
    n_cmp++; if (ramREN !== 1'b1 || dwait !== 1'b1) begin n_bad++; $display("FAIL wd_serve got ren=%0h dw=%0h want 1 1", ramREN, dwait); end
    cyc(); dREN = 1'b0; #2;
    n_cmp++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin n_bad++; $display("FAIL wd_drop got ren=%0h wen=%0h dw=%0h want 0 0 1", ramREN, ramWEN, dwait); end
    ramstate = ACCESS;
    cyc(); #2;
    n_cmp++; if (dwait !== 1'b1 || ramREN !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL wd_idle got dw=%0h ren=%0h err=%0h want 1 0 0", dwait, ramREN, err); end
    ramstate = FREE;
  endtask

  task automatic test_midreset();
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h11112222; ramstate = BUSY;
    cyc(); #2;
    n_cmp++; if (ramWEN !== 1'b1 || ramaddr !== 32'h300) begin n_bad++; $display("FAIL mr_serve got wen=%0h addr=%h want 1 00000300", ramWEN, ramaddr); end
    ramstate = ACCESS;
    #1 nRST = 1'b0;
    #1;
    n_cmp++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_bad++; $display("FAIL mr_async got wen=%0h ren=%0h addr=%h st=%h want 0 0 0 0", ramWEN, ramREN, ramaddr, ramstore); end
    n_cmp++; if (dwait !== 1'b1 || iwait !== 1'b1) begin n_bad++; $display("FAIL mr_waits got dw=%0h iw=%0h want 1 1", dwait, iwait); end
    ramstate = BUSY;
    cyc(); nRST = 1'b1; #2;
    n_cmp++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin n_bad++; $display("FAIL mr_idle got wen=%0h dw=%0h want 0 1", ramWEN, dwait); end
    cyc(); #2;
    n_cmp++; if (ramWEN !== 1'b1 || ramaddr !== 32'h300 || ramstore !== 32'h11112222) begin n_bad++; $display("FAIL mr_rearb got wen=%0h addr=%h st=%h want 1 00000300 11112222", ramWEN, ramaddr, ramstore); end
    cyc(); ramstate = ACCESS; #2;
    n_cmp++; if (dwait !== 1'b0) begin n_bad++; $display("FAIL mr_complete got dw=%0h want 0", dwait); end
    cyc(); dWEN = 1'b0; ramstate = FREE;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FREE;
    #1;
    test_reset();
    test_priority();
    test_iread();
    test_dread();
    test_rr();
    test_timeout();
    test_ram_error();
    test_withdraw();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum serve-state cycles without RAM completion before a forced abort.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 iREN  input  1  icache read request, held until iwait low.
REQ-005 iaddr  input  32  icache word address.
REQ-006 iwait  output  1  icache stall; low for exactly the completion cycle.
REQ-007 iload  output  32  icache read data.
REQ-008 dREN  input  1  dcache read request.
REQ-009 dWEN  input  1  dcache write request.
REQ-010 daddr  input  32  dcache word address.
REQ-011 dstore  input  32  dcache write data.
REQ-012 dwait  output  1  dcache stall; low for exactly the completion cycle.
REQ-013 dload  output  32  dcache read data.
REQ-014 ramREN, ramWEN  output  1 each  RAM read and write strobes.
REQ-015 ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-016 ramload  input  32  RAM read data.
REQ-017 ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-018 err  output  1  sticky error flag: timeout or RAM ERROR.

Function
REQ-019 FSM states: IDLE, DSERVE, ISERVE; the state register is updated only on the clock edge.
REQ-020 IDLE: if dREN or dWEN is asserted, next state SHALL be DSERVE; else if iREN, next ISERVE; else stay in IDLE.
REQ-021 In IDLE, all RAM strobes SHALL be low, and iwait and dwait SHALL both be high.
REQ-022 DSERVE: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN; write wins when both are set.
REQ-023 ISERVE: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-024 Completion: in a serve state with ramstate==ACCESS, the granted wait SHALL go low combinationally that cycle and the next state SHALL be IDLE.
REQ-025 iload and dload SHALL equal ramload combinationally, except in timeout-abort cycles (see REQ-028).
REQ-026 Minimum latency, request to completion: 2 cycles (1 grant cycle plus at least 1 RAM cycle); back-to-back requests pass through IDLE for 1 cycle.
REQ-027 ramstate==ERROR in a serve state: treat the cycle as a completion (granted wait low, return to IDLE) and set err.
REQ-028 A serve-cycle counter SHALL clear on entry to a serve state; on reaching TIMEOUT without completion, the block SHALL:
  - force completion that cycle;
  - drive the granted load output to 32'hBAD1BAD1;
  - set err.
REQ-029 Request withdrawn mid-serve (granted request low): next state IDLE, no wait pulse, strobes low that cycle.
REQ-030 Non-granted wait SHALL stay high at all times; both waits SHALL never be low in the same cycle.
REQ-031 err SHALL remain set until reset.

Reset
REQ-032 On nRST low, asynchronously:
  - state IDLE, counter 0, err 0;
  - iwait=1, dwait=1;
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-033 Reset mid-serve SHALL abandon the transaction with no wait pulse; after release, a request held high SHALL be re-arbitrated from IDLE.

Configuration
REQ-034 Macro MEM_ARBITER_RR_EN. Defined: a one-bit last-grant register is kept; when both sides request in IDLE, the side not granted last wins. Undefined: fixed dcache priority per REQ-020.

Verification
REQ-035 iREN=1, iaddr=0x40, ramstate ACCESS on the 2nd cycle -> ramREN/ramaddr=0x40 in cycle 1, iwait low in cycle 2, iload=ramload.
REQ-036 dWEN=1 and iREN=1 simultaneously (RR undefined) -> DSERVE first with ramWEN=1; ISERVE after an IDLE cycle; iwait stays high throughout the dcache transfer.
REQ-037 With MEM_ARBITER_RR_EN: after a dcache grant, a simultaneous d+i request -> icache granted first.
REQ-038 TIMEOUT=4, ramstate held BUSY -> dwait low on the 4th serve cycle, dload=0xBAD1BAD1, err=1 and sticky.
REQ-039 nRST pulsed low during DSERVE -> all outputs at reset values immediately; no dwait pulse; re-arbitration after release.
REQ-040 dREN dropped in a BUSY cycle of DSERVE -> IDLE next cycle, dwait never low, err=0.
